// File: rtl/ascon_perm_ctrl.sv
// Round sequencer for the ASCON permutation: loads the state register, walks the
// round-constant index through 12/8/6 rounds and pulses done when the last round is written.
module ascon_perm_ctrl #(
  parameter int unsigned NR_A  = 12,
  parameter int unsigned NR_B8 = 8,
  parameter int unsigned NR_B6 = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] rounds_sel_i,
  output logic [3:0] round_o,
  output logic       sel_init_o,
  output logic       en_reg_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       ready_o
);

  localparam int unsigned RCNT_W     = 4;
  localparam int unsigned MAX_ROUNDS = 12;
  localparam int unsigned LAST_ROUND = MAX_ROUNDS - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_ROUND = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic [RCNT_W-1:0] first_rnd;
  logic              sel_init_q, en_reg_q, busy_q, done_q, ready_q;

  // Reduced-round runs start part-way so the final round constant is always index 11.
  always_comb begin
    first_rnd = RCNT_W'(MAX_ROUNDS - NR_A);
    case (rounds_sel_i)
      2'b01:   first_rnd = RCNT_W'(MAX_ROUNDS - NR_B8);
      2'b10:   first_rnd = RCNT_W'(MAX_ROUNDS - NR_B6);
      default: first_rnd = RCNT_W'(MAX_ROUNDS - NR_A);
    endcase
  end

  // Next state and round counter; start is only honoured while ready.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      S_IDLE: begin
        rcnt_d = '0;
        if (start_i) begin
          state_d = S_LOAD;
          rcnt_d  = first_rnd;
        end
      end
      S_LOAD: begin
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (rcnt_q >= RCNT_W'(LAST_ROUND)) begin
          state_d = S_DONE;
          rcnt_d  = RCNT_W'(LAST_ROUND);
        end else begin
          rcnt_d = rcnt_q + RCNT_W'(1);
        end
      end
      S_DONE: begin
        if (start_i) begin
          state_d = S_LOAD;
          rcnt_d  = first_rnd;
        end else begin
          state_d = S_IDLE;
          rcnt_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  // State register with outputs decoded from the next state so they are registered.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      rcnt_q     <= '0;
      sel_init_q <= 1'b0;
      en_reg_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      sel_init_q <= (state_d == S_LOAD);
      en_reg_q   <= (state_d == S_LOAD) || (state_d == S_ROUND);
      busy_q     <= (state_d == S_LOAD) || (state_d == S_ROUND);
      done_q     <= (state_d == S_DONE);
      ready_q    <= (state_d == S_IDLE) || (state_d == S_DONE);
    end
  end

  assign round_o    = rcnt_q;
  assign sel_init_o = sel_init_q;
  assign en_reg_o   = en_reg_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign ready_o    = ready_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Self-checking bench for ascon_perm_ctrl: expected write-enable cycles are queued at
// start and popped as the DUT produces them.
module tb_ascon_perm_ctrl;

  typedef struct packed {
    logic       sel;
    logic [3:0] rnd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] rsel = 2'b00;
  logic [3:0] round_o;
  logic       sel_init_o, en_reg_o, busy_o, done_o, ready_o;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  ascon_perm_ctrl dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .start_i     (start),
    .rounds_sel_i(rsel),
    .round_o     (round_o),
    .sel_init_o  (sel_init_o),
    .en_reg_o    (en_reg_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ready_o     (ready_o)
  );

  always #5 clk = ~clk;

  function automatic int first_of(input logic [1:0] s);
    case (s)
      2'b01:   return 4;
      2'b10:   return 6;
      default: return 0;
    endcase
  endfunction

  // Queue the LOAD write followed by one write per round.
  task automatic push_run(input logic [1:0] s);
    exp_t e;
    int   f;
    f = first_of(s);
    e.sel = 1'b1; e.rnd = 4'(f);
    q.push_back(e);
    for (int k = 0; k < 12 - f; k++) begin
      e.sel = 1'b0; e.rnd = 4'(f + k);
      q.push_back(e);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0;
    step; step;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_assert++;
      if ({round_o, sel_init_o, en_reg_o, busy_o, done_o, ready_o} !== {4'd0, 5'b00001}) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d got round=%0d sel=%b en=%b busy=%b done=%b ready=%b want 0/0/0/0/0/1",
                 c, round_o, sel_init_o, en_reg_o, busy_o, done_o, ready_o);
      end
      step;
    end
  endtask

  // One full run for a given select, checking every write cycle, done timing and return to idle.
  task automatic test_run(input logic [1:0] s);
    exp_t e;
    int   cyc, nr, en_cnt;
    nr = 12 - first_of(s);
    rsel = s; start = 1'b1; push_run(s);
    step;
    start = 1'b0; rsel = ~s;
    cyc = 1; en_cnt = 0;
    while (q.size() > 0 && cyc < 40) begin
      e = q.pop_front();
      en_cnt += int'(en_reg_o);
      n_assert++;
      if ({en_reg_o, busy_o, done_o, ready_o, sel_init_o, round_o} !== {4'b1100, e.sel, e.rnd}) begin
        n_fail++;
        $display("FAIL run_write sel=%b cyc=%0d got en=%b busy=%b done=%b ready=%b init=%b round=%0d want 1/1/0/0/%b/%0d",
                 s, cyc, en_reg_o, busy_o, done_o, ready_o, sel_init_o, round_o, e.sel, e.rnd);
      end
      step; cyc++;
    end
    n_assert++;
    if ({done_o, ready_o, en_reg_o, busy_o, round_o} !== {4'b1100, 4'd11} || cyc != nr + 2) begin
      n_fail++;
      $display("FAIL run_done sel=%b cyc=%0d got done=%b ready=%b en=%b busy=%b round=%0d want done at cyc %0d round 11",
               s, cyc, done_o, ready_o, en_reg_o, busy_o, round_o, nr + 2);
    end
    n_assert++;
    if (en_cnt != nr + 1) begin
      n_fail++;
      $display("FAIL run_en_count sel=%b got %0d want %0d", s, en_cnt, nr + 1);
    end
    step;
    n_assert++;
    if ({done_o, ready_o, en_reg_o, busy_o, round_o} !== {4'b0100, 4'd0}) begin
      n_fail++;
      $display("FAIL run_idle sel=%b got done=%b ready=%b en=%b busy=%b round=%0d want 0/1/0/0/0",
               s, done_o, ready_o, en_reg_o, busy_o, round_o);
    end
  endtask

  task automatic test_rounds;
    for (int i = 0; i < 4; i++) test_run(2'(i));
  endtask

  task automatic test_start_while_busy;
    exp_t e;
    int   cyc, done_cnt;
    rsel = 2'b00; start = 1'b1; push_run(2'b00);
    step;
    start = 1'b0;
    cyc = 1;
    while (q.size() > 0 && cyc < 40) begin
      e = q.pop_front();
      n_assert++;
      if ({en_reg_o, sel_init_o, round_o} !== {1'b1, e.sel, e.rnd}) begin
        n_fail++;
        $display("FAIL busy_write cyc=%0d got en=%b init=%b round=%0d want 1/%b/%0d",
                 cyc, en_reg_o, sel_init_o, round_o, e.sel, e.rnd);
      end
      start = (round_o == 4'd5 && !sel_init_o);
      rsel  = 2'b10;
      step; cyc++;
    end
    start = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      done_cnt += int'(done_o);
      n_assert++;
      if (en_reg_o !== 1'b0 || (c > 0 && ready_o !== 1'b1)) begin
        n_fail++;
        $display("FAIL busy_no_second_run c=%0d got en=%b ready=%b want 0/1", c, en_reg_o, ready_o);
      end
      step;
    end
    n_assert++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL busy_single_done got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   cyc;
    rsel = 2'b00; start = 1'b1; push_run(2'b00);
    step;
    start = 1'b0;
    cyc = 1;
    while (q.size() > 0 && cyc < 40) begin
      e = q.pop_front();
      step; cyc++;
    end
    n_assert++;
    if (done_o !== 1'b1 || cyc != 14) begin
      n_fail++;
      $display("FAIL b2b_first_done cyc=%0d got done=%b want 1 at cyc 14", cyc, done_o);
    end
    rsel = 2'b10; start = 1'b1; push_run(2'b10);
    step;
    start = 1'b0;
    cyc = 1;
    while (q.size() > 0 && cyc < 40) begin
      e = q.pop_front();
      n_assert++;
      if ({en_reg_o, busy_o, done_o, sel_init_o, round_o} !== {3'b110, e.sel, e.rnd}) begin
        n_fail++;
        $display("FAIL b2b_write cyc=%0d got en=%b busy=%b done=%b init=%b round=%0d want 1/1/0/%b/%0d",
                 cyc, en_reg_o, busy_o, done_o, sel_init_o, round_o, e.sel, e.rnd);
      end
      step; cyc++;
    end
    n_assert++;
    if (done_o !== 1'b1 || round_o !== 4'd11 || cyc != 8) begin
      n_fail++;
      $display("FAIL b2b_second_done cyc=%0d got done=%b round=%0d want 1 at cyc 8 round 11", cyc, done_o, round_o);
    end
    step;
  endtask

  task automatic test_reset_mid_run;
    int cyc, done_cnt;
    rsel = 2'b00; start = 1'b1; push_run(2'b00);
    step;
    start = 1'b0;
    cyc = 0;
    while (!(round_o == 4'd7 && !sel_init_o) && cyc < 40) begin
      step; cyc++;
    end
    n_assert++;
    if (cyc != 8) begin
      n_fail++;
      $display("FAIL mid_reach_round7 got cyc=%0d want 8", cyc);
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    q.delete();
    n_assert++;
    if ({round_o, sel_init_o, en_reg_o, busy_o, done_o, ready_o} !== {4'd0, 5'b00001}) begin
      n_fail++;
      $display("FAIL mid_reset_idle got round=%0d sel=%b en=%b busy=%b done=%b ready=%b want 0/0/0/0/0/1",
               round_o, sel_init_o, en_reg_o, busy_o, done_o, ready_o);
    end
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      done_cnt += int'(done_o) + int'(en_reg_o);
      step;
    end
    n_assert++;
    if (done_cnt != 0) begin
      n_fail++;
      $display("FAIL mid_no_done got %0d activity cycles want 0", done_cnt);
    end
    test_run(2'b00);
  endtask

  initial begin
    test_reset;
    test_rounds;
    test_start_while_busy;
    test_back_to_back;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ascon_perm_ctrl.md
Name: ascon_perm_ctrl

Overview:
- Round sequencer for the ASCON permutation datapath: add_const -> couche_substitution -> couche_diffusion, looping through an external 5x64 state register.
- On a start request it:
  - loads the input state into the state register;
  - steps the round-constant index through nr rounds (12, 8 or 6);
  - enables the state register once per round;
  - reports completion with a one-cycle pulse.
- Sits between the top-level ASCON FSM (initialisation / associated data / plaintext / finalisation phases) and the permutation datapath.

Parameters:
- NR_A, 12, round count for pa (rounds_sel_i = 2'b00 and the reserved 2'b11)
- NR_B8, 8, round count for rounds_sel_i = 2'b01
- NR_B6, 6, round count for rounds_sel_i = 2'b10

Ports:
- clock_i  input  1  system clock, all state updates on rising edge
- reset_i  input  1  synchronous, active-high reset
- start_i  input  1  permutation request; sampled only in IDLE or DONE
- rounds_sel_i  input  2  round-count select: 00 -> 12, 01 -> 8, 10 -> 6, 11 -> 12; sampled with accepted start only
- round_o  output  4  round-constant index driven to add_const
- sel_init_o  output  1  state-register input mux: 1 = external input state, 0 = permutation output
- en_reg_o  output  1  state-register write enable
- busy_o  output  1  high in LOAD and ROUND
- done_o  output  1  one-cycle completion pulse, high in DONE
- ready_o  output  1  high in IDLE and DONE; a start is accepted in these states

Behaviour:
- All outputs are Moore-decoded from registered state (FSM state plus 4-bit round counter rcnt). There is no combinational path from inputs to outputs.
- Reset (synchronous, reset_i=1 at an edge):
  - state=IDLE, rcnt=0.
  - Next cycle outputs: round_o=0, sel_init_o=0, en_reg_o=0, busy_o=0, done_o=0, ready_o=1.
  - Reset has priority over every other input.
- States:
  - IDLE:
    - ready_o=1; all other outputs 0; rcnt held at 0.
    - start_i=1 -> LOAD, with rcnt <= 12 - nr (nr decoded from rounds_sel_i).
  - LOAD (exactly 1 cycle):
    - sel_init_o=1, en_reg_o=1, busy_o=1; round_o=rcnt.
    - Unconditional transition to ROUND.
  - ROUND (exactly nr cycles):
    - sel_init_o=0, en_reg_o=1, busy_o=1; round_o=rcnt.
    - If rcnt=11 -> DONE and rcnt holds; else rcnt <= rcnt+1.
  - DONE (1 cycle):
    - done_o=1, ready_o=1, en_reg_o=0; round_o=11.
    - start_i=1 -> LOAD, with rcnt <= 12 - nr of the new rounds_sel_i (back-to-back operation).
    - Otherwise -> IDLE with rcnt <= 0.
- Round index sequences:
  - 12 rounds: 0..11.
  - 8 rounds: 4..11.
  - 6 rounds: 6..11.
  - The last round index is always 11 (0xB).
- Latency: start accepted at edge T -> LOAD in cycle T+1 -> ROUND in cycles T+2..T+nr+1 -> done_o in cycle T+nr+2.
  - 12 rounds: 14 cycles from acceptance to done.
  - Total en_reg_o pulses per run: nr+1.
- start_i in LOAD or ROUND is ignored; no queuing. rounds_sel_i changes after acceptance have no effect.
- rcnt never exceeds 11 and never wraps. Any illegal state encoding recovers to IDLE with rcnt=0 on the next edge.
- Reset mid-operation: the next edge forces IDLE with all outputs inactive. done_o is not emitted for the aborted run.

Test Plan:
- Reset: hold reset_i=1 for 2 cycles, then release -> round_o=0, sel_init_o=0, en_reg_o=0, busy_o=0, done_o=0, ready_o=1; no change while start_i=0.
- 12-round run: start_i=1 for one cycle with rounds_sel_i=00 ->
  - 1 cycle sel_init_o=1 with round_o=0;
  - round_o=0,1,...,11 over 12 cycles with en_reg_o=1;
  - done_o=1 exactly 14 cycles after acceptance;
  - 13 en_reg_o pulses total.
- 8- and 6-round runs: rounds_sel_i=01 gives round_o=4..11 with done_o 10 cycles after start. rounds_sel_i=10 gives round_o=6..11 with done_o 8 cycles after start. rounds_sel_i=11 behaves identically to 00.
- Start while busy: assert start_i with rounds_sel_i=10 during round_o=5 of a 12-round run -> sequence unaffected, single done_o, no second run.
- Back-to-back: start_i=1 with rounds_sel_i=10 in the DONE cycle of a 12-round run -> LOAD next cycle with round_o=6, no IDLE cycle, second done_o 8 cycles later.
- Reset mid-run: reset_i=1 at round_o=7 -> next cycle IDLE, round_o=0, en_reg_o=0, no done_o. A subsequent start runs a complete, correct 12-round sequence.
